truth_table_probe: RTL and testbench

// Characterises a combinational logic block, the inverse of a truth-table gate. It walks every input

---
 rtl/truth_table_probe.sv | 171 +++++++++++++++++
 tb/tb_truth_table_probe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_probe.sv
// Truth-table probe: sweeps every input vector into an external combinational block,
// majority-samples its output per vector and assembles the hex truth-table code.
module truth_table_probe #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLES       = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 dut_out_i,
  output logic [N_IN-1:0]      drive_in_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [(1<<N_IN)-1:0] tt_o,
  output logic                 tt_valid_o,
  output logic                 glitch_o
);

  localparam int TT_W    = 1 << N_IN;
  localparam int VEC_W   = N_IN + 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ONES_W  = $clog2(SAMPLES + 1);

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLES - 1);
  localparam logic [ONES_W-1:0] ONES_HALF   = ONES_W'(SAMPLES / 2);
  localparam logic [ONES_W-1:0] ONES_FULL   = ONES_W'(SAMPLES);
  localparam logic [VEC_W-1:0]  VEC_LAST    = VEC_W'(TT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_e;

  state_e            state_q;
  logic [VEC_W-1:0]  vec_q;
  logic [VEC_W-1:0]  vec_d;
  logic [CNT_W-1:0]  phaseCnt_q;
  logic [ONES_W-1:0] ones_q;
  logic [ONES_W-1:0] ones_d;
  logic [N_IN-1:0]   drive_q;
  logic              busy_q;
  logic              done_q;
  logic [TT_W-1:0]   tt_q;
  logic [TT_W-1:0]   tt_d;
  logic [TT_W-1:0]   ttMask;
  logic              ttValid_q;
  logic              glitch_q;
  logic              glitch_d;
  logic              vote;
  logic              split;
  logic              lastVec;
  logic              lastSettle;
  logic              lastSample;

  // ones_d includes the sample being taken this cycle, so the final vote needs no extra cycle
  always_comb begin
    ones_d     = ones_q + ONES_W'(dut_out_i);
    vote       = (ones_d > ONES_HALF);
    split      = (ones_d != '0) && (ones_d != ONES_FULL);
    vec_d      = vec_q + VEC_W'(1);
    lastVec    = (vec_q == VEC_LAST);
    lastSettle = (phaseCnt_q == SETTLE_LAST);
    lastSample = (phaseCnt_q == SAMPLE_LAST);
    ttMask     = '0;
    for (int i = 0; i < TT_W; i++) begin
      ttMask[i] = (vec_q == VEC_W'(TT_W - 1 - i));
    end
    tt_d     = vote ? (tt_q | ttMask) : (tt_q & ~ttMask);
    glitch_d = glitch_q | split;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      phaseCnt_q <= '0;
      ones_q     <= '0;
      drive_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tt_q       <= '0;
      ttValid_q  <= 1'b0;
      glitch_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i && !abort_i) begin
            state_q    <= SETTLE;
            vec_q      <= '0;
            phaseCnt_q <= '0;
            ones_q     <= '0;
            drive_q    <= '0;
            busy_q     <= 1'b1;
            tt_q       <= '0;
            ttValid_q  <= 1'b0;
            glitch_q   <= 1'b0;
          end
        end

        SETTLE: begin
          if (abort_i) begin
            state_q    <= IDLE;
            phaseCnt_q <= '0;
            ones_q     <= '0;
            drive_q    <= '0;
            busy_q     <= 1'b0;
          end else if (lastSettle) begin
            state_q    <= SAMPLE;
            phaseCnt_q <= '0;
          end else begin
            phaseCnt_q <= phaseCnt_q + CNT_W'(1);
          end
        end

        SAMPLE: begin
          if (abort_i) begin
            state_q    <= IDLE;
            phaseCnt_q <= '0;
            ones_q     <= '0;
            drive_q    <= '0;
            busy_q     <= 1'b0;
          end else if (lastSample) begin
            tt_q       <= tt_d;
            glitch_q   <= glitch_d;
            ones_q     <= '0;
            phaseCnt_q <= '0;
            if (lastVec) begin
              state_q   <= FINISH;
              done_q    <= 1'b1;
              ttValid_q <= 1'b1;
              busy_q    <= 1'b0;
              drive_q   <= '0;
            end else begin
              state_q <= SETTLE;
              vec_q   <= vec_d;
              drive_q <= vec_d[N_IN-1:0];
            end
          end else begin
            ones_q     <= ones_d;
            phaseCnt_q <= phaseCnt_q + CNT_W'(1);
          end
        end

        FINISH: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          drive_q <= '0;
        end
      endcase
    end
  end

  assign drive_in_o = drive_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign tt_o       = tt_q;
  assign tt_valid_o = ttValid_q;
  assign glitch_o   = glitch_q;

endmodule

// File: tb/tb_truth_table_probe.sv
// Bench for truth_table_probe: directed sweeps on a 3-input and a 2-input instance,
// completed sweeps checked by scoreboard monitors triggered on the done pulse.
module tb_truth_table_probe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN;
  logic       start8, abort8, dut8;
  logic [2:0] drive8;
  logic       busy8, done8, ttValid8, glitch8;
  logic [7:0] tt8;

  logic       start4, abort4, dut4;
  logic [1:0] drive4;
  logic       busy4, done4, ttValid4, glitch4;
  logic [3:0] tt4;

  logic [7:0] fTable;
  logic       forceHigh;

  truth_table_probe dut (
    .clk_i      (clk),
    .rst_n_i    (rstN),
    .start_i    (start8),
    .abort_i    (abort8),
    .dut_out_i  (dut8),
    .drive_in_o (drive8),
    .busy_o     (busy8),
    .done_o     (done8),
    .tt_o       (tt8),
    .tt_valid_o (ttValid8),
    .glitch_o   (glitch8)
  );

  truth_table_probe #(.N_IN(2), .SETTLE_CYCLES(1), .SAMPLES(1)) dutSmall (
    .clk_i      (clk),
    .rst_n_i    (rstN),
    .start_i    (start4),
    .abort_i    (abort4),
    .dut_out_i  (dut4),
    .drive_in_o (drive4),
    .busy_o     (busy4),
    .done_o     (done4),
    .tt_o       (tt4),
    .tt_valid_o (ttValid4),
    .glitch_o   (glitch4)
  );

  // Gate models: tt[TT_W-1-v] = f(v), so the bit for vector v sits at index ~v
  always_comb dut8 = fTable[~drive8] | forceHigh;
  always_comb dut4 = drive4[1] ^ drive4[0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] tt;
    logic       glitch;
    int         startCyc;
    int         lat;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic startVal, input logic abortVal);
    start8 = startVal;
    abort8 = abortVal;
    tick();
    start8 = 1'b0;
    abort8 = 1'b0;
  endtask

  task automatic expect8(input logic [7:0] t, input logic g);
    exp_t e;
    e.tt = t;
    e.glitch = g;
    e.startCyc = cyc;
    e.lat = 56;
    q8.push_back(e);
  endtask

  task automatic drain8(input int budget);
    int n = 0;
    while (q8.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain8", q8.size(), 0);
  endtask

  logic prevDone8 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      checkOutput("done8_pulse", prevDone8, 1'b0);
      if (q8.size() == 0) begin
        checkOutput("done8_queue_depth", q8.size(), 1);
      end else begin
        e = q8.pop_front();
        checkOutput("tt8", tt8, e.tt);
        checkOutput("glitch8", glitch8, e.glitch);
        checkOutput("ttValid8", ttValid8, 1'b1);
        checkOutput("busy8_finish", busy8, 1'b0);
        checkOutput("drive8_finish", drive8, 3'd0);
        checkOutput("done8_latency", cyc - e.startCyc, e.lat);
      end
    end
    prevDone8 = done8;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      if (q4.size() == 0) begin
        checkOutput("done4_queue_depth", q4.size(), 1);
      end else begin
        e = q4.pop_front();
        checkOutput("tt4", tt4, e.tt);
        checkOutput("glitch4", glitch4, e.glitch);
        checkOutput("ttValid4", ttValid4, 1'b1);
        checkOutput("done4_latency", cyc - e.startCyc, e.lat);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneCount;
    exp_t e4;
    int n;
    rstN = 1'b0;
    start8 = 1'b0;
    abort8 = 1'b0;
    start4 = 1'b0;
    abort4 = 1'b0;
    fTable = 8'h3E;
    forceHigh = 1'b0;
    repeat (3) tick();
    checkOutput("rst_busy", busy8, 1'b0);
    checkOutput("rst_done", done8, 1'b0);
    checkOutput("rst_tt", tt8, 8'h00);
    checkOutput("rst_ttValid", ttValid8, 1'b0);
    checkOutput("rst_glitch", glitch8, 1'b0);
    checkOutput("rst_drive", drive8, 3'd0);
    checkOutput("rst_busy4", busy4, 1'b0);
    rstN = 1'b1;
    tick();

    // Full sweep of f=3E, with a stray start mid-sweep that must be ignored
    applyStimulus(1'b1, 1'b0);
    expect8(8'h3E, 1'b0);
    for (int v = 0; v < 8; v++) begin
      checkOutput($sformatf("sweep_drive_v%0d", v), drive8, v);
      checkOutput($sformatf("sweep_busy_v%0d", v), busy8, 1'b1);
      for (int k = 0; k < 7; k++) begin
        if (v == 1 && k == 0) start8 = 1'b1;
        tick();
        start8 = 1'b0;
      end
    end
    checkOutput("done_cycle57", done8, 1'b1);
    tick();
    checkOutput("hold_done", done8, 1'b0);
    checkOutput("hold_tt", tt8, 8'h3E);
    checkOutput("hold_ttValid", ttValid8, 1'b1);
    checkOutput("hold_busy", busy8, 1'b0);

    // Vector 3 high on two of three samples, otherwise f=01
    fTable = 8'h01;
    applyStimulus(1'b1, 1'b0);
    expect8(8'h11, 1'b1);
    checkOutput("start_clears_ttValid", ttValid8, 1'b0);
    checkOutput("start_clears_tt", tt8, 8'h00);
    repeat (25) tick();
    checkOutput("glitch_drive_v3", drive8, 3'd3);
    forceHigh = 1'b1;
    repeat (2) tick();
    forceHigh = 1'b0;
    drain8(100);

    // Abort at cycle 20, then a clean sweep
    fTable = 8'h3E;
    applyStimulus(1'b1, 1'b0);
    repeat (19) tick();
    checkOutput("abort_pre_busy", busy8, 1'b1);
    checkOutput("abort_pre_drive", drive8, 3'd2);
    abort8 = 1'b1;
    tick();
    abort8 = 1'b0;
    checkOutput("abort_busy", busy8, 1'b0);
    checkOutput("abort_drive", drive8, 3'd0);
    checkOutput("abort_ttValid", ttValid8, 1'b0);
    repeat (70) tick();
    checkOutput("abort_idle_busy", busy8, 1'b0);
    applyStimulus(1'b1, 1'b0);
    expect8(8'h3E, 1'b0);
    drain8(100);

    // Start and abort together in IDLE: abort wins
    applyStimulus(1'b1, 1'b1);
    checkOutput("start_abort_busy", busy8, 1'b0);
    repeat (5) tick();
    checkOutput("start_abort_idle", busy8, 1'b0);

    // Start held for 100 cycles: one done inside the window, a second sweep from IDLE
    doneCount = 0;
    start8 = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (k == 0) expect8(8'h3E, 1'b0);
      if (k == 57) checkOutput("held_idle_busy", busy8, 1'b0);
      if (k == 58) begin
        checkOutput("held_restart_busy", busy8, 1'b1);
        expect8(8'h3E, 1'b0);
      end
      if (done8) doneCount++;
    end
    start8 = 1'b0;
    checkOutput("held_done_count", doneCount, 1);
    drain8(100);

    // Reset during SAMPLE of vector 5
    applyStimulus(1'b1, 1'b0);
    repeat (40) tick();
    checkOutput("rst5_pre_drive", drive8, 3'd5);
    checkOutput("rst5_pre_busy", busy8, 1'b1);
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    checkOutput("rst5_busy", busy8, 1'b0);
    checkOutput("rst5_drive", drive8, 3'd0);
    checkOutput("rst5_done", done8, 1'b0);
    checkOutput("rst5_tt", tt8, 8'h00);
    checkOutput("rst5_ttValid", ttValid8, 1'b0);
    checkOutput("rst5_glitch", glitch8, 1'b0);
    repeat (60) tick();
    checkOutput("rst5_idle_busy", busy8, 1'b0);

    // Small instance: XOR gate, expected 4'h6 at cycle 9
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    e4.tt = 8'h06;
    e4.glitch = 1'b0;
    e4.startCyc = cyc;
    e4.lat = 8;
    q4.push_back(e4);
    n = 0;
    while (q4.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("drain4", q4.size(), 0);

    drain8(10);
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
